// File: rtl/seq_alu.sv
// seq_alu: RV32I/RV32M execute unit. Base ops finish in one cycle; multiply and
// divide iterate one bit per cycle and end with a sign-fixup cycle.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SLTU   = 5'b00110;
  localparam logic [4:0] OP_SLL    = 5'b00111;
  localparam logic [4:0] OP_AND    = 5'b01000;
  localparam logic [4:0] OP_SRA    = 5'b01101;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d, rneg_q, rneg_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic             zero_q, zero_d, busy_q, busy_d;

  // Operand decode for the acceptance cycle
  logic             a_sgn, b_sgn, a_neg, b_neg, is_mul, is_div, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b, quick_res;
  logic [SHW-1:0]   shamt;

  assign is_mul   = (op_i[4:2] == 3'b100);
  assign is_div   = (op_i[4:2] == 3'b101);
  assign a_sgn    = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                    (op_i == OP_DIV) || (op_i == OP_REM);
  assign b_sgn    = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                    (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_neg    = a_sgn & a_i[WIDTH-1];
  assign b_neg    = b_sgn & b_i[WIDTH-1];
  assign mag_a    = a_neg ? -a_i : a_i;
  assign mag_b    = b_neg ? -b_i : b_i;
  assign div_zero = (b_i == '0);
  assign div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                    (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
  assign shamt    = b_i[SHW-1:0];

  // Single-cycle results: base ops, divide special cases, undefined ops
  always_comb begin
    quick_res = '0;
    case (op_i)
      OP_ADD:  quick_res = a_i + b_i;
      OP_SUB:  quick_res = a_i - b_i;
      OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_XOR:  quick_res = a_i ^ b_i;
      OP_OR:   quick_res = a_i | b_i;
      OP_AND:  quick_res = a_i & b_i;
      OP_SLL:  quick_res = a_i << shamt;
      OP_SRL:  quick_res = a_i >> shamt;
      OP_SRA:  quick_res = $signed(a_i) >>> shamt;
      OP_DIV, OP_DIVU: quick_res = div_zero ? '1 : a_i;
      OP_REM, OP_REMU: quick_res = div_zero ? a_i : '0;
      default: quick_res = '0;
    endcase
  end

  // Datapath for one multiply step, one restoring-divide step and the fixups
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
  assign rem_sh   = {hi_q, lo_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = rneg_q ? -hi_q : hi_q;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          op_d  = op_i;
          cnt_d = '0;
          if (is_mul) begin
            state_d = S_MUL;
            hi_d    = '0;
            lo_d    = mag_b;
            opnd_d  = mag_a;
            neg_d   = a_neg ^ b_neg;
            busy_d  = 1'b1;
          end else if (is_div && !div_zero && !div_ovf) begin
            state_d = S_DIV;
            hi_d    = '0;
            lo_d    = mag_a;
            opnd_d  = mag_b;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            busy_d  = 1'b1;
          end else begin
            state_d     = S_DONE;
            result_d    = quick_res;
            zero_d      = (quick_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d     = S_DONE;
          result_d    = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
          zero_d      = (result_d == '0);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
          cnt_d        = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d     = S_DONE;
          result_d    = op_q[1] ? rem_fix : quo_fix;
          zero_d      = (result_d == '0);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          if (!rem_diff[WIDTH]) begin
            hi_d = rem_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = rem_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against a behavioural
// reference model built on plain 64-bit arithmetic.
module tb_seq_alu;

  localparam int unsigned W = 32;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, SLT = 5'b00010, OR_ = 5'b00011;
  localparam logic [4:0] XOR_ = 5'b00100, SRL = 5'b00101, SLTU = 5'b00110, SLL = 5'b00111;
  localparam logic [4:0] AND_ = 5'b01000, SRA = 5'b01101;
  localparam logic [4:0] MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010, MULHU = 5'b10011;
  localparam logic [4:0] DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [W-1:0] a, b, result;
  logic [4:0]   op;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .op_i        (op),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .zero_o      (zero),
    .busy_o      (busy)
  );

  // Reference: RISC-V semantics straight from the arithmetic definitions
  function automatic logic [W-1:0] ref_alu(input logic [4:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    int q;
    sx = $signed(x);
    sy = $signed(y);
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    case (o)
      ADD:  return x + y;
      SUB:  return x - y;
      SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      SLTU: return (x < y) ? 32'd1 : 32'd0;
      XOR_: return x ^ y;
      OR_:  return x | y;
      AND_: return x & y;
      SLL:  return x << y[4:0];
      SRL:  return x >> y[4:0];
      SRA:  begin q = $signed(x) >>> y[4:0]; return q; end
      MUL:    begin p = sx * sy; return p[31:0]; end
      MULH:   begin p = sx * sy; return p[63:32]; end
      MULHSU: begin p = sx * uy; return p[63:32]; end
      MULHU:  begin p = ux * uy; return p[63:32]; end
      DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        q = $signed(x) / $signed(y);
        return q;
      end
      REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        q = $signed(x) % $signed(y);
        return q;
      end
      DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      REMU: return (y == 0) ? x : x % y;
      default: return 32'h0;
    endcase
  endfunction

  // Cycles from acceptance to visible out_valid: iterative ops take WIDTH+1
  function automatic int ref_lat(input logic [4:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    if (o inside {MUL, MULH, MULHSU, MULHU}) return W + 1;
    if (o inside {DIV, DIVU, REM, REMU}) begin
      if (y == 0) return 0;
      if ((o == DIV || o == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
      return W + 1;
    end
    return 0;
  endfunction

  // Offer one op, scramble inputs after acceptance, wait (bounded) for out_valid
  task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ordy, output logic [W-1:0] res, output logic z,
                       output int lat, output int busy_cnt, output int rdy_cnt);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 5'($urandom);
    lat = 0; busy_cnt = 0; rdy_cnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cnt++;
      if (in_ready) rdy_cnt++;
      @(negedge clk);
      lat++;
    end
    res = result;
    z   = zero;
  endtask

  task automatic drain(output logic ov, output logic ir);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ov = out_valid;
    ir = in_ready;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    #1;
    checks++;
    if ({in_ready, out_valid, zero, busy} !== 4'b1000 || result !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy/ov/z/busy=%b result=%h required 1000 / 0",
               {in_ready, out_valid, zero, busy}, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add_zero();
    logic [W-1:0] r; logic z, ov, ir; int lat, bc, rc;
    issue(ADD, 32'd5, 32'hFFFF_FFFB, 1'b1, r, z, lat, bc, rc);
    checks++;
    if (r !== 32'h0 || z !== 1'b1 || lat != 0) begin
      errors++;
      $display("FAIL add_zero: result=%h zero=%b lat=%0d required 0 1 0", r, z, lat);
    end
    drain(ov, ir);
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      errors++;
      $display("FAIL add_zero_release: out_valid=%b in_ready=%b required 0 1", ov, ir);
    end
  endtask

  task automatic test_multiply();
    vec_t v[3];
    logic [W-1:0] r; logic z, ov, ir; int lat, bc, rc;
    v[0] = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    v[1] = '{MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    v[2] = '{MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, 1'b0, r, z, lat, bc, rc);
      checks++;
      if (r !== v[i].exp || z !== (v[i].exp == 0)) begin
        errors++;
        $display("FAIL mul_result[%0d]: got %h z=%b required %h", i, r, z, v[i].exp);
      end
      checks++;
      if (lat != W + 1 || bc != W + 1 || rc != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mul_timing[%0d]: lat=%0d busy_cycles=%0d ready_cycles=%0d required %0d %0d 0",
                 i, lat, bc, rc, W + 1, W + 1);
      end
      drain(ov, ir);
    end
  endtask

  task automatic test_divide();
    vec_t v[4];
    logic [W-1:0] r; logic z, ov, ir; int lat, bc, rc;
    v[0] = '{DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    v[1] = '{REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    v[2] = '{DIVU, 32'd100,       32'd7, 32'd14};
    v[3] = '{REMU, 32'd100,       32'd7, 32'd2};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, 1'b0, r, z, lat, bc, rc);
      checks++;
      if (r !== v[i].exp || lat != W + 1) begin
        errors++;
        $display("FAIL div[%0d]: got %h lat=%0d required %h lat=%0d", i, r, lat, v[i].exp, W + 1);
      end
      drain(ov, ir);
    end
  endtask

  task automatic test_special();
    vec_t v[4];
    logic [W-1:0] r; logic z, ov, ir; int lat, bc, rc;
    v[0] = '{DIVU, 32'd13,          32'd0,         32'hFFFF_FFFF};
    v[1] = '{REMU, 32'd13,          32'd0,         32'd13};
    v[2] = '{DIV,  32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000};
    v[3] = '{REM,  32'h8000_0000,   32'hFFFF_FFFF, 32'h0};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, 1'b0, r, z, lat, bc, rc);
      checks++;
      if (r !== v[i].exp || z !== (v[i].exp == 0) || lat != 0 || bc != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL special[%0d]: got %h z=%b lat=%0d busy_cycles=%0d required %h lat 0 busy 0",
                 i, r, z, lat, bc, v[i].exp);
      end
      drain(ov, ir);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r; logic z, ov, ir; int lat, bc, rc;
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, z, lat, bc, rc);
    checks++;
    if (r !== 32'hFFFF_FFFE || lat != W + 1) begin
      errors++;
      $display("FAIL bp_result: got %h lat=%0d required fffffffe lat=%0d", r, lat, W + 1);
    end
    for (int i = 0; i < 5; i++) begin
      op = ADD; a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (result !== 32'hFFFF_FFFE || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: result=%h ov=%b rdy=%b z=%b required fffffffe 1 0 0",
                 i, result, out_valid, in_ready, zero);
      end
    end
    in_valid = 1'b0;
    drain(ov, ir);
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", ov, ir);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x1, y1, x2, y2;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    @(negedge clk);
    op = XOR_; a = x1; b = y1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = SUB; a = x2; b = y2;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== (x1 ^ y1)) begin
      errors++;
      $display("FAIL b2b_first: ov=%b rdy=%b result=%h required 1 0 %h",
               out_valid, in_ready, result, x1 ^ y1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: ov=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== (x2 - y2)) begin
      errors++;
      $display("FAIL b2b_second: ov=%b result=%h required 1 %h", out_valid, result, x2 - y2);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r; logic z, ov, ir; int lat, bc, rc;
    @(negedge clk);
    op = DIV; a = 32'd1000; b = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: busy=%b ov=%b required 1 0", busy, out_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: ov=%b busy=%b rdy=%b required 0 0 1", out_valid, busy, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    issue(SRA, 32'h8000_0000, 32'd4, 1'b0, r, z, lat, bc, rc);
    checks++;
    if (r !== 32'hF800_0000 || lat != 0) begin
      errors++;
      $display("FAIL post_reset_sra: got %h lat=%0d required f8000000 lat 0", r, lat);
    end
    drain(ov, ir);
  endtask

  task automatic test_random();
    logic [4:0] ops[18] = '{ADD, SUB, SLT, SLTU, XOR_, OR_, AND_, SLL, SRL, SRA,
                            MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    logic [4:0] o; logic [W-1:0] x, y, r, e; logic z, ov, ir; int lat, bc, rc, el;
    for (int i = 0; i < 60; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 17)];
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 9))
        0: y = '0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      e  = ref_alu(o, x, y);
      el = ref_lat(o, x, y);
      issue(o, x, y, 1'($urandom), r, z, lat, bc, rc);
      checks++;
      if (r !== e || z !== (e == 0) || lat != el) begin
        errors++;
        $display("FAIL rand[%0d] op=%b a=%h b=%h: got %h z=%b lat=%0d required %h z=%b lat=%0d",
                 i, o, x, y, r, z, lat, e, (e == 0), el);
      end
      drain(ov, ir);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_zero();
    test_multiply();
    test_divide();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
